// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI-to-mem command sequencer:
// opcodes, command byte field positions and FSM state encoding.
package spi_mem_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_INIT  = 2'b11;

  localparam int CMD_OP_HI   = 7;
  localparam int CMD_OP_LO   = 6;
  localparam int CMD_RSV_HI  = 5;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_DATA = 3'd1;
  localparam logic [2:0] S_WRITE     = 3'd2;
  localparam logic [2:0] S_READ      = 3'd3;
  localparam logic [2:0] S_READ_WAIT = 3'd4;
  localparam logic [2:0] S_READ_RESP = 3'd5;
  localparam logic [2:0] S_INIT      = 3'd6;
  localparam logic [2:0] S_DRAIN     = 3'd7;

  function automatic logic cmd_rsv_ok(input logic [7:0] cmd);
    return cmd[CMD_RSV_HI:CMD_RSV_LO] == 2'b00;
  endfunction

endpackage

// File: rtl/spi_mem_ctrl.sv
// Command sequencer between the SPI slave byte interface and the 16x8 mem block.
// Define SPI_MEM_BURST_EN for auto-incrementing burst writes/reads within one frame.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int INIT_CYC = 2
) (
  input  logic              mem_clk,
  input  logic              mem_rst,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_byte,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_byte,
  output logic              busy,
  output logic              err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] buffer_rx,
  input  logic [DATA_W-1:0] buffer_tx,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_initial
);

  localparam int CNT_MAX = (RD_LAT > INIT_CYC) ? RD_LAT : INIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_CYC - 1);

  logic [2:0]        state, state_nxt, done_state;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic [DATA_W-1:0] rdata, rdata_nxt;
  logic              err_q, err_nxt;
  logic              frame_end, frame_end_nxt;
  logic              burst_rd, burst_rd_nxt;
  logic              cs_q;
  logic              en_q;
  logic              byte_in;
  logic              cs_fall;
  logic [1:0]        op;

  // A byte arriving together with cs_n high is dropped silently.
  assign byte_in = rx_valid & ~cs_n;
  assign cs_fall = cs_q & ~cs_n;
  assign op      = rx_byte[CMD_OP_HI:CMD_OP_LO];

  // Where a finished strobe goes: an ended frame always returns to IDLE.
  always_comb begin
    if (frame_end | cs_n) begin
      done_state = S_IDLE;
    end else begin
`ifdef SPI_MEM_BURST_EN
      done_state = S_WAIT_DATA;
`else
      done_state = S_DRAIN;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    addr_nxt      = addr;
    wdata_nxt     = wdata;
    rdata_nxt     = rdata;
    err_nxt       = err_q;
    frame_end_nxt = frame_end | cs_n;
    burst_rd_nxt  = burst_rd;
    if (cs_fall) err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        frame_end_nxt = 1'b0;
        burst_rd_nxt  = 1'b0;
        if (byte_in) begin
          if (!cmd_rsv_ok(rx_byte[7:0])) begin
            err_nxt   = 1'b1;
            state_nxt = S_DRAIN;
          end else begin
            case (op)
              OP_WRITE: begin
                addr_nxt  = ADDR_W'(rx_byte[CMD_ADDR_HI:CMD_ADDR_LO]);
                state_nxt = S_WAIT_DATA;
              end
              OP_READ: begin
                addr_nxt  = ADDR_W'(rx_byte[CMD_ADDR_HI:CMD_ADDR_LO]);
                state_nxt = S_READ;
              end
              OP_INIT: begin
                cnt_nxt   = INIT_LOAD;
                state_nxt = S_INIT;
              end
              default: state_nxt = S_DRAIN;
            endcase
          end
        end
      end
      S_WAIT_DATA: begin
        if (cs_n) begin
          state_nxt = S_IDLE;
        end else if (rx_valid) begin
          if (burst_rd) begin
            state_nxt = S_READ;
          end else begin
            wdata_nxt = rx_byte;
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (byte_in) err_nxt = 1'b1;
        state_nxt = done_state;
`ifdef SPI_MEM_BURST_EN
        addr_nxt = addr + ADDR_W'(1);
`endif
      end
      S_READ: begin
        if (byte_in) err_nxt = 1'b1;
        cnt_nxt   = RD_LOAD;
        state_nxt = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (byte_in) err_nxt = 1'b1;
        if (cnt == '0) begin
          rdata_nxt = buffer_tx;
          state_nxt = S_READ_RESP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_READ_RESP: begin
        if (byte_in) err_nxt = 1'b1;
        state_nxt = done_state;
`ifdef SPI_MEM_BURST_EN
        addr_nxt     = addr + ADDR_W'(1);
        burst_rd_nxt = 1'b1;
`endif
      end
      S_INIT: begin
        if (byte_in) err_nxt = 1'b1;
        if (cnt == '0) begin
          state_nxt = done_state;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cs_n) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A new error in the same cycle as a frame start still sticks.
    if (byte_in && state == S_IDLE && !cmd_rsv_ok(rx_byte[7:0])) err_nxt = 1'b1;
  end

  always_ff @(posedge mem_clk or posedge mem_rst) begin
    if (mem_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr      <= '0;
      wdata     <= '0;
      rdata     <= '0;
      err_q     <= 1'b0;
      frame_end <= 1'b0;
      burst_rd  <= 1'b0;
      cs_q      <= 1'b1;
      en_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr      <= addr_nxt;
      wdata     <= wdata_nxt;
      rdata     <= rdata_nxt;
      err_q     <= err_nxt;
      frame_end <= frame_end_nxt;
      burst_rd  <= burst_rd_nxt;
      cs_q      <= cs_n;
      en_q      <= 1'b1;
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign mem_we      = (state == S_WRITE);
  assign mem_re      = (state == S_READ);
  assign mem_initial = (state == S_INIT);
  assign tx_load     = (state == S_READ_RESP);
  assign busy        = (state != S_IDLE);
  assign tx_byte     = rdata;
  assign buffer_rx   = wdata;
  assign mem_address = addr;
  assign err         = err_q;
  assign mem_en      = en_q;

endmodule
